// File: rtl/prng_stream.sv
// prng_stream: wide xor-shift pseudo-random word generator with warm-up,
// seed loading and a valid/ready output port.
//
// Handshake: a word transfers on a posedge where out_valid and out_ready are
// both 1. out_valid does not depend on out_ready. While out_valid is 1 and
// out_ready is 0, out_data holds its value.
module prng_stream #(
    parameter int              WIDTH  = 1024,
    parameter int              OUT_W  = 64,
    parameter int              T0     = 10,
    parameter int              T1     = 50,
    parameter int              T2     = 180,
    parameter int              T3     = 512,
    parameter int              T4     = 895,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int              WARMUP = 16
) (
    input  logic             clk,
    input  logic             reset,       // asynchronous, active low
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] state_out,
    output logic             seed_err,
    output logic [31:0]      word_count,
    output logic             dbg_run      // 1 when the FSM is in RUN
);

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_state_nxt;
    logic [WIDTH-1:0] w_stepped;
    logic [15:0]      r_warm;
    logic [15:0]      w_warm_nxt;
    logic [31:0]      r_count;
    logic [31:0]      w_count_nxt;
    logic             r_seed_err;
    logic             w_err_nxt;
    logic             w_seed_zero;

    localparam logic [15:0] WARM_INIT = 16'(WARMUP);

    // A tap of 0 is disabled; a tap reaching past the MSB would shift in only
    // zeros, so it is dropped as well.
    function automatic logic [WIDTH-1:0] tap(input logic [WIDTH-1:0] s, input int t);
        if (t > 0 && t < WIDTH) return s >> t;
        return '0;
    endfunction

    // Step function: state xor its enabled right-shifted copies.
    always_comb begin
        w_stepped = r_state ^ tap(r_state, T0) ^ tap(r_state, T1) ^ tap(r_state, T2)
                  ^ tap(r_state, T3) ^ tap(r_state, T4);
    end

    assign w_seed_zero = (seed_in == '0);

    // Next-state logic: seed load wins over everything, en=0 freezes the rest.
    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm;
        w_fsm_nxt   = r_fsm;
        w_count_nxt = r_count;
        w_err_nxt   = 1'b0;
        if (seed_load) begin
            w_state_nxt = w_seed_zero ? SEED : seed_in;
            w_warm_nxt  = WARM_INIT;
            w_err_nxt   = w_seed_zero;
            // With no warm-up, an enabled load cycle is itself the first
            // enabled cycle, so the new seed is offered on the next cycle.
            w_fsm_nxt   = (WARMUP == 0 && en) ? ST_RUN : ST_WARM;
        end else if (en) begin
            case (r_fsm)
                ST_WARM: begin
                    if (r_warm == 16'd0) begin
                        w_fsm_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = w_stepped;
                        w_warm_nxt  = r_warm - 16'd1;
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        w_state_nxt = w_stepped;
                        if (r_count != 32'hFFFF_FFFF) w_count_nxt = r_count + 32'd1;
                    end
                end
                default: w_fsm_nxt = ST_WARM;
            endcase
        end
    end

    // State register bank with asynchronous reset to the seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm      <= ST_WARM;
            r_state    <= SEED;
            r_warm     <= WARM_INIT;
            r_count    <= 32'd0;
            r_seed_err <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_state    <= w_state_nxt;
            r_warm     <= w_warm_nxt;
            r_count    <= w_count_nxt;
            r_seed_err <= w_err_nxt;
        end
    end

    assign out_valid  = (r_fsm == ST_RUN) && en;
    assign out_data   = r_state[OUT_W-1:0];
    assign state_out  = r_state;
    assign seed_err   = r_seed_err;
    assign word_count = r_count;
    assign dbg_run    = (r_fsm == ST_RUN);

endmodule

// File: tb/tb_prng_stream.sv
// Bench for prng_stream: small 8-bit instances for directed vectors and the
// default-parameter instance for a long random handshake run.
module tb_prng_stream;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: WIDTH 8, WARMUP 0 ----------------
    logic       a_en, a_load, a_rdy, a_valid, a_err, a_run;
    logic [7:0] a_seed, a_data, a_state;
    logic [31:0] a_count;

    prng_stream #(.WIDTH(8), .OUT_W(8), .T0(1), .T1(2), .T2(3), .T3(4), .T4(5),
                  .SEED(8'hFF), .WARMUP(0)) dut_a (
        .clk(clk), .reset(reset), .en(a_en), .seed_load(a_load), .seed_in(a_seed),
        .out_ready(a_rdy), .out_valid(a_valid), .out_data(a_data), .state_out(a_state),
        .seed_err(a_err), .word_count(a_count), .dbg_run(a_run));

    // ---------------- instance C: WIDTH 8, WARMUP 3 ----------------
    logic       c_en, c_load, c_rdy, c_valid, c_err, c_run;
    logic [7:0] c_seed, c_data, c_state;
    logic [31:0] c_count;

    prng_stream #(.WIDTH(8), .OUT_W(8), .T0(1), .T1(2), .T2(3), .T3(4), .T4(5),
                  .SEED(8'hFF), .WARMUP(3)) dut_c (
        .clk(clk), .reset(reset), .en(c_en), .seed_load(c_load), .seed_in(c_seed),
        .out_ready(c_rdy), .out_valid(c_valid), .out_data(c_data), .state_out(c_state),
        .seed_err(c_err), .word_count(c_count), .dbg_run(c_run));

    // ---------------- instance B: default parameters ----------------
    logic          b_en, b_load, b_rdy, b_valid, b_err, b_run;
    logic [1023:0] b_seed, b_state;
    logic [63:0]   b_data;
    logic [31:0]   b_count;

    prng_stream dut_b (
        .clk(clk), .reset(reset), .en(b_en), .seed_load(b_load), .seed_in(b_seed),
        .out_ready(b_rdy), .out_valid(b_valid), .out_data(b_data), .state_out(b_state),
        .seed_err(b_err), .word_count(b_count), .dbg_run(b_run));

    // ---------------- reference models ----------------
    function automatic logic [7:0] step8(input logic [7:0] s);
        return s ^ (s >> 1) ^ (s >> 2) ^ (s >> 3) ^ (s >> 4) ^ (s >> 5);
    endfunction

    function automatic logic [1023:0] step_def(input logic [1023:0] s);
        return s ^ (s >> 10) ^ (s >> 50) ^ (s >> 180) ^ (s >> 512) ^ (s >> 895);
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        load;
        logic [7:0]  seed;
        logic        en;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [31:0] exp_count;
        logic        exp_err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];

    initial begin
        logic [7:0]    e8;
        logic [1023:0] m;
        logic          m_run;
        int            m_warm;
        int            hs;
        int            n;
        logic          exp_v;
        logic [63:0]   got;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        a_en = 1'b0; a_load = 1'b0; a_rdy = 1'b0; a_seed = 8'h00;
        c_en = 1'b0; c_load = 1'b0; c_rdy = 1'b0; c_seed = 8'h00;
        b_en = 1'b0; b_load = 1'b0; b_rdy = 1'b0; b_seed = '0;

        //            load  seed   en    rdy   | valid data   count  err
        vecs[0]  = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 8'hFF, 32'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h80, 32'd0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFC, 32'd1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 32'd2, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 32'd2, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 32'd2, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 32'd2, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 32'd2, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAA, 32'd2, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hAA, 32'd2, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 32'd2, 1'b0};
        vecs[11] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hCF, 32'd3, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 32'd3, 1'b0};
        vecs[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 32'd3, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 32'd3, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 32'd3, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 32'd3, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 32'd3, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 32'd3, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA8, 32'd4, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_state", 64'(a_state), 64'hFF);
        chk("rst_a_valid", 64'(a_valid), 64'h0);
        chk("rst_a_count", 64'(a_count), 64'h0);
        chk("rst_a_err",   64'(a_err),   64'h0);
        @(negedge clk);
        reset = 1'b1;

        // directed vectors on A
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            a_load = vecs[i].load;
            a_seed = vecs[i].seed;
            a_en   = vecs[i].en;
            a_rdy  = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(a_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("v%0d_data",  i), 64'(a_data),  64'(vecs[i].exp_data));
            chk($sformatf("v%0d_count", i), 64'(a_count), 64'(vecs[i].exp_count));
            chk($sformatf("v%0d_err",   i), 64'(a_err),   64'(vecs[i].exp_err));
        end

        // asynchronous reset between edges while A is in RUN
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(a_valid), 64'h0);
        chk("arst_count", 64'(a_count), 64'h0);
        chk("arst_state", 64'(a_state), 64'hFF);
        chk("arst_run",   64'(a_run),   64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        a_en = 1'b0; a_load = 1'b0; a_rdy = 1'b0;

        // warm-up length on C: 3 stepped cycles plus one transition cycle
        @(posedge clk);
        #1;
        c_en  = 1'b1;
        c_rdy = 1'b1;
        n = 0;
        @(negedge clk);
        while (!c_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        e8 = 8'hFF;
        for (int k = 0; k < 3; k++) e8 = step8(e8);
        chk("warm_cycles", 64'(n), 64'd4);
        chk("warm_data", 64'(c_data), 64'(e8));
        @(posedge clk);
        #1;
        c_rdy = 1'b0;
        chk("warm_count", 64'(c_count), 64'd1);

        // zero seed on C: substitute SEED, one-cycle error pulse, back in WARM
        c_load = 1'b1;
        c_seed = 8'h00;
        @(posedge clk);
        #1;
        c_load = 1'b0;
        @(negedge clk);
        chk("zseed_state", 64'(c_state), 64'hFF);
        chk("zseed_err",   64'(c_err),   64'h1);
        chk("zseed_run",   64'(c_run),   64'h0);
        chk("zseed_valid", 64'(c_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("zseed_err_clr", 64'(c_err), 64'h0);
        c_en = 1'b0;

        // default-parameter random run against the reference model
        m      = '1;
        m_run  = 1'b0;
        m_warm = 16;
        hs     = 0;
        for (int cyc = 0; cyc < 60000 && hs < 10000; cyc++) begin
            @(posedge clk);
            #1;
            b_en  = ($urandom_range(0, 9) != 0);
            b_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_v = m_run && b_en;
            if (b_valid !== exp_v) chk("rand_valid", 64'(b_valid), 64'(exp_v));
            if (exp_v && b_rdy) begin
                exp_q.push_back(m[63:0]);
                m = step_def(m);
                hs++;
            end else if (!m_run && b_en) begin
                if (m_warm == 0) begin
                    m_run = 1'b1;
                end else begin
                    m = step_def(m);
                    m_warm--;
                end
            end
            if (b_valid && b_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_word", 64'(b_data), 64'h0);
                end else begin
                    got = exp_q.pop_front();
                    chk("rand_data", b_data, got);
                end
            end
        end
        chk("rand_handshakes", 64'(hs), 64'd10000);
        @(posedge clk);
        #1;
        b_en  = 1'b0;
        b_rdy = 1'b0;
        chk("rand_count", 64'(b_count), 64'(hs));
        chk("rand_q_empty", 64'(exp_q.size()), 64'd0);
        checks++;
        if (b_state !== m) begin
            errors++;
            $display("FAIL rand_state low128 actual=%0h required=%0h", b_state[127:0], m[127:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_stream.md
PRNG_STREAM -- requirements
Module: prng_stream

Interface
REQ-001 Parameter WIDTH, default 1024: generator state width in bits, legal range 8..4096.
REQ-002 Parameter OUT_W, default 64: output word width, legal range 1..WIDTH.
REQ-003 Parameters T0..T4, defaults 10, 50, 180, 512, 895: right-shift tap distances. 0 = tap disabled; a tap >= WIDTH contributes zero.
REQ-004 Parameter SEED, default all ones (WIDTH bits): reset and substitute seed value.
REQ-005 Parameter WARMUP, default 16: state steps discarded after reset or seed load, legal range 0..65535.
REQ-006 clk  in  1  single clock; all flops rise on posedge clk.
REQ-007 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-008 en  in  1  global enable; 0 freezes all state except reset and seed load.
REQ-009 seed_load  in  1  one-cycle request to load seed_in.
REQ-010 seed_in  in  WIDTH  new seed value.
REQ-011 out_ready  in  1  consumer accepts out_data this cycle.
REQ-012 out_valid  out  1  out_data holds a fresh word.
REQ-013 out_data  out  OUT_W  bits [OUT_W-1:0] of the current state.
REQ-014 state_out  out  WIDTH  full current state, always visible.
REQ-015 seed_err  out  1  one-cycle pulse: an all-zero seed was rejected.
REQ-016 word_count  out  32  count of accepted words, saturating at 0xFFFFFFFF.

Function
REQ-017 The step function SHALL be next = s ^ (s>>T0) ^ (s>>T1) ^ (s>>T2) ^ (s>>T3) ^ (s>>T4), with disabled taps omitted and logical shifts zero-filled.
REQ-018 The FSM SHALL have two states: WARM and RUN. Reset and every seed load enter WARM with warm counter = WARMUP.
REQ-019 In WARM with en=1, the state SHALL step once per cycle and the counter SHALL decrement. At counter 0 the FSM SHALL move to RUN without stepping that cycle. If WARMUP=0, RUN is entered on the first enabled cycle.
REQ-020 out_valid SHALL be 1 exactly when FSM=RUN and en=1. It SHALL be 0 in WARM.
REQ-021 In RUN, the state SHALL step on the clock edge where out_valid and out_ready are both 1. Otherwise the state and out_data SHALL hold.
REQ-022 Output latency SHALL be zero: out_data and state_out reflect the state register directly, with no output pipeline stage.
REQ-023 word_count SHALL increment on each handshake and saturate at 0xFFFFFFFF. Seed load does not clear it; only reset does.
REQ-024 When en=0, the state, warm counter, FSM and word_count SHALL hold, and out_valid SHALL be 0.
REQ-025 A seed load SHALL take effect regardless of en and SHALL take priority over a simultaneous handshake. The word offered that cycle is not counted and not stepped.
REQ-026 An all-zero seed_in SHALL load SEED instead and pulse seed_err for one cycle. Any nonzero seed loads verbatim.
REQ-027 A nonzero state SHALL never step to zero; the step function is invertible, and no further zero detection is required.

Reset
REQ-028 While reset=0, the following SHALL hold asynchronously:
- state = SEED
- FSM = WARM, warm counter = WARMUP
- word_count = 0, seed_err = 0, out_valid = 0
REQ-029 Reset deassertion mid-operation SHALL restart warm-up from SEED. No pre-reset state is retained.

Verification
All scenarios use WIDTH=8, OUT_W=8, T0..T4=1,2,3,4,5 unless stated otherwise.
REQ-030 WARMUP=0, seed_load with seed_in=0x80, en=1, out_ready=1:
- cycle after load: out_data=0x80, out_valid=1
- then 0xFC, then 0xAA
- word_count=2 after the two handshakes.
REQ-031 WARMUP=3, reset released, en=1:
- out_valid=0 for 3 stepped cycles plus 1 transition cycle
- first valid out_data equals SEED stepped 3 times per a reference model.
REQ-032 In RUN, hold out_ready=0 for 5 cycles: out_data is stable and word_count unchanged. Toggle en=0 for 2 cycles: out_valid=0 and nothing advances.
REQ-033 seed_load with seed_in=0x00: state=SEED, seed_err=1 for exactly one cycle, FSM=WARM.
REQ-034 seed_load coincident with out_valid=1 and out_ready=1: new seed loaded, word_count unchanged.
REQ-035 Reset asserted mid-RUN, asynchronously between clock edges: outputs clear immediately with no clock edge required. Then default parameters, 10000 random handshakes compared bit-exact against the reference model.
